// File: rtl/stepper_pkg.sv
// Shared encodings for the stepper driver: drive modes, coil phase table and phase index width.
package stepper_pkg;

  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    MODE_WAVE = 2'b00,
    MODE_FULL = 2'b01,
    MODE_HALF = 2'b10
  } mode_e;

  // Coil pattern {B',A',B,A} per phase index; A/A' and B/B' are never both on.
  localparam logic [3:0] COIL_TABLE [8] = '{
    4'b0001, 4'b0011, 4'b0010, 4'b0110,
    4'b0100, 4'b1100, 4'b1000, 4'b1001
  };

endpackage

// File: rtl/step_timer.sv
// Internal step generator: prescaler ticks every PRESCALE clocks, a step fires on the tick that
// finds the period counter equal to the programmed count, so steps arrive every (period+1)*PRESCALE.
module step_timer #(
  parameter int PRESCALE = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] period,
  output logic       step
);

  localparam int PW = $clog2(PRESCALE);

  logic [PW-1:0] pre;
  logic [7:0]    cnt;
  logic          tick;

  assign tick = enable && (pre == PW'(PRESCALE - 1));
  // Equality only: if period drops below cnt, cnt runs on to 255, wraps and meets it later.
  assign step = tick && (cnt == period);

  always_ff @(posedge clk) begin
    if (!rst_n || !enable) begin
      pre <= '0;
      cnt <= '0;
    end else begin
      pre <= tick ? '0 : pre + 1'b1;
      if (step)      cnt <= '0;
      else if (tick) cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/stepper_driver.sv
// Tiny Tapeout stepper driver: phase index advanced by synchronized external pulses or the
// internal step timer, decoded to wave/full/half coil patterns.
module stepper_driver
  import stepper_pkg::*;
#(
  parameter int PRESCALE = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic             ext_ctrl, dir, drive_en, run;
  logic [1:0]       mode;
  logic             sync1, sync2, hist;
  logic             ext_edge, timer_step, step_event;
  logic [IDX_W-1:0] idx, inc, sel;
  logic             strobe;
  logic [3:0]       coils;
  logic             unused_ok;

  assign ext_ctrl = ui_in[0];
  assign dir      = ui_in[2];
  assign mode     = ui_in[4:3];
  assign drive_en = ui_in[5];
  assign run      = ui_in[6];
  assign unused_ok = &{1'b0, ena, ui_in[7]};

  step_timer #(.PRESCALE(PRESCALE)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (!ext_ctrl && run),
    .period (uio_in),
    .step   (timer_step)
  );

  // Two-flop synchronizer on the async step input, plus a history flop for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
    end else begin
      sync1 <= ui_in[1];
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign ext_edge   = sync2 && !hist;
  assign step_event = ext_ctrl ? ext_edge : timer_step;
  assign inc        = mode[1] ? IDX_W'(1) : IDX_W'(2);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx    <= '0;
      strobe <= 1'b0;
    end else begin
      strobe <= step_event;
      if (step_event) idx <= dir ? idx + inc : idx - inc;
    end
  end

  always_comb begin
    sel = idx;
    if (mode[1])                sel = idx;
    else if (mode == MODE_FULL) sel = idx | IDX_W'(1);
    else                        sel = idx & IDX_W'(6);
    coils = drive_en ? COIL_TABLE[sel] : 4'b0000;
  end

  assign uo_out  = {strobe, idx, coils};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_stepper_driver.sv
// Directed bench for stepper_driver: external half/wave/full stepping, internal timer period,
// drive-enable masking and mid-run reset.
module tb_stepper_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int cmp_cnt = 0;
  int err_cnt = 0;

  stepper_driver dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    cmp_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic edges(input int n, output int strobes);
    strobes = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (uo_out[7]) strobes++;
    end
  endtask

  // Clean external pulse: high 3 edges (idx moves on the 3rd), then low 3 edges.
  task automatic ext_pulse(input string tag, input logic [7:0] exp_byte);
    int s;
    ui_in[1] = 1'b1;
    edges(3, s);
    chk(tag, uo_out, exp_byte);
    ui_in[1] = 1'b0;
    edges(3, s);
    chk({tag, "_quiet"}, {7'd0, uo_out[7]}, 8'd0);
  endtask

  // Expected {strobe, idx, coils} right after each step.
  logic [7:0] half_exp [8] = '{8'h93, 8'hA2, 8'hB6, 8'hC4, 8'hDC, 8'hE8, 8'hF9, 8'h81};
  logic [7:0] wave_exp [4] = '{8'h91, 8'hB2, 8'hD4, 8'hF8};
  logic [7:0] full_exp [4] = '{8'h93, 8'hB6, 8'hDC, 8'hF9};

  initial begin
    int s;
    rst_n  = 1'b0;
    ena    = 1'b1;
    uio_in = 8'd0;
    ui_in  = 8'h35;  // ext_ctrl, dir fwd, half, drive_en
    edges(2, s);
    chk("reset_uo", uo_out, 8'h01);
    chk("reset_uio_out", uio_out, 8'h00);
    chk("reset_uio_oe", uio_oe, 8'h00);
    rst_n = 1'b1;
    edges(2, s);
    chk("idle_no_step", uo_out, 8'h01);

    for (int i = 0; i < 8; i++) ext_pulse($sformatf("half_fwd%0d", i), half_exp[i]);
    ui_in[2] = 1'b0;
    ext_pulse("half_rev", 8'hF9);

    ui_in[2]   = 1'b1;
    ui_in[4:3] = 2'b00;
    for (int i = 0; i < 4; i++) ext_pulse($sformatf("wave%0d", i), wave_exp[i]);
    ui_in[4:3] = 2'b01;
    for (int i = 0; i < 4; i++) ext_pulse($sformatf("full%0d", i), full_exp[i]);

    // Internal timer, P=3: steps every 1024 clocks, idx 7 -> 1 -> 3.
    uio_in = 8'd3;
    ui_in  = 8'h2C;
    edges(2, s);
    ui_in  = 8'h6C;
    edges(1023, s);
    chk("int_first_gap", 8'(s), 8'd0);
    edges(1, s);
    chk("int_first_step", uo_out, 8'h93);
    edges(1023, s);
    chk("int_second_gap", 8'(s), 8'd0);
    edges(1, s);
    chk("int_second_step", uo_out, 8'hB6);

    // Drive disabled: coils off, idx still advances.
    ui_in = 8'h4C;
    #1;
    chk("dis_coils_off", {4'd0, uo_out[3:0]}, 8'h00);
    edges(1024, s);
    chk("dis_step", uo_out, 8'hD0);
    ui_in = 8'h6C;
    #1;
    chk("reenable", uo_out, 8'hDC);

    // Mid-run reset, then the timer restarts from zero.
    edges(500, s);
    rst_n = 1'b0;
    edges(1, s);
    chk("midrst_uo", uo_out, 8'h03);
    chk("midrst_uio", uio_out | uio_oe, 8'h00);
    rst_n = 1'b1;
    edges(1023, s);
    chk("post_rst_gap", 8'(s), 8'd0);
    edges(1, s);
    chk("post_rst_step", uo_out, 8'hA6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
